// File: rtl/ntt_pkg.sv
// ntt_pkg
// Constants and types shared by the NTT twiddle datapath: the Goldilocks
// field modulus, word width, the 2^32-1 folding constant, the twiddle ROM
// write codes, and the state encoding of the stage-0 row generator.
package ntt_pkg;

  localparam int          DW    = 64;
  localparam logic [63:0] P_MOD = 64'hFFFF_FFFF_0000_0001;
  // 2^64 mod p; used to fold the high product word back into the field.
  localparam logic [63:0] EPS   = 64'h0000_0000_FFFF_FFFF;

  localparam logic [1:0]  W_IDLE = 2'd0;
  localparam logic [1:0]  W_ROW0 = 2'd1;
  localparam logic [1:0]  W_ROW1 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_EMIT0,
    ST_EMIT1,
    ST_FIN
  } state_t;

endpackage

// File: rtl/goldilocks_mulmod.sv
// goldilocks_mulmod
// Two-stage pipelined 64x64 modular multiplier over the Goldilocks field.
// Stage 1 registers the full 128-bit product, stage 2 registers the reduced,
// canonical result. valid_o follows valid_i two cycles later.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   valid_i  operands a_i/b_i are valid this cycle
//   a_i,b_i  canonical operands (< p)
//   valid_o  res_o holds a new result this cycle
//   res_o    (a_i * b_i) mod p, canonical
module goldilocks_mulmod
  import ntt_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic        valid_o,
  output logic [63:0] res_o
);

  logic [127:0] prod_q;
  logic         prodValid_q;
  logic [63:0]  res_q;
  logic [63:0]  res_d;
  logic         resValid_q;

  logic [63:0]  xl;
  logic [31:0]  hiA;
  logic [31:0]  hiB;
  logic [63:0]  t0;
  logic [63:0]  t1;
  logic [64:0]  sum;
  logic [63:0]  s0;

  // Stage 1: capture the raw 128-bit product.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q      <= '0;
      prodValid_q <= 1'b0;
    end else begin
      prodValid_q <= valid_i;
      if (valid_i) begin
        prod_q <= {64'd0, a_i} * {64'd0, b_i};
      end
    end
  end

  // Reduction: with x = a*2^96 + b*2^64 + xl, 2^64 = EPS and 2^96 = -1 mod p,
  // so x = xl - a + b*EPS. Subtracting a can borrow (fixed by adding p, which
  // in 64-bit wraparound is subtracting EPS); adding b*EPS can carry out of
  // bit 63 (2^64 = EPS again). The sum then lies below 2^64 < 2p, so a single
  // conditional subtract makes it canonical.
  always_comb begin
    xl  = prod_q[63:0];
    hiB = prod_q[95:64];
    hiA = prod_q[127:96];
    t0  = xl - {32'd0, hiA};
    if (xl < {32'd0, hiA}) begin
      t0 = t0 - EPS;
    end
    t1  = ({32'd0, hiB} << 32) - {32'd0, hiB};
    sum = {1'b0, t0} + {1'b0, t1};
    s0  = sum[63:0];
    if (sum[64]) begin
      s0 = s0 + EPS;
    end
    res_d = (s0 >= P_MOD) ? (s0 - P_MOD) : s0;
  end

  // Stage 2: register the canonical result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q      <= '0;
      resValid_q <= 1'b0;
    end else begin
      resValid_q <= prodValid_q;
      if (prodValid_q) begin
        res_q <= res_d;
      end
    end
  end

  assign valid_o = resValid_q;
  assign res_o   = res_q;

endmodule

// File: rtl/tw_row_gen.sv
// tw_row_gen
// Stage-0 twiddle row generator. On start it captures two bases, computes
// powers 0..3 of each modulo p with a shared pipelined multiplier, then
// writes them to the twiddle ROM as two contiguous 4-beat bursts (row0 with
// code 1, row1 with code 2) followed by a one-cycle done pulse.
//
// Ports:
//   CLK                  clock, rising edge
//   rst                  asynchronous active-high reset
//   start                request pulse, only honoured in IDLE
//   base0_in, base1_in   row bases, reduced to canonical form on capture
//   horizontal_row0_out  row0 word while ROM2_w == 1, else 0
//   horizontal_row1_out  row1 word while ROM2_w == 2, else 0
//   ROM2_w               write code: 0 idle, 1 row0 beat, 2 row1 beat
//   busy                 transaction in progress
//   done                 one-cycle pulse after the last row1 beat
module tw_row_gen
  import ntt_pkg::state_t;
  import ntt_pkg::ST_IDLE;
  import ntt_pkg::ST_CALC;
  import ntt_pkg::ST_EMIT0;
  import ntt_pkg::ST_EMIT1;
  import ntt_pkg::ST_FIN;
  import ntt_pkg::W_IDLE;
  import ntt_pkg::W_ROW0;
  import ntt_pkg::W_ROW1;
#(
  parameter int            DW    = ntt_pkg::DW,
  parameter logic [DW-1:0] P_MOD = ntt_pkg::P_MOD,
  parameter int            N_POW = 4
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] base0_in,
  input  logic [DW-1:0] base1_in,
  output logic [DW-1:0] horizontal_row0_out,
  output logic [DW-1:0] horizontal_row1_out,
  output logic [1:0]    ROM2_w,
  output logic          busy,
  output logic          done
);

  localparam int          BW        = (N_POW > 1) ? $clog2(N_POW) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_POW - 1);
  localparam logic [DW-1:0] ONE       = {{(DW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [1:0]    dest_q;
  logic          accept;

  logic [DW-1:0] pw0_q [N_POW];
  logic [DW-1:0] pw1_q [N_POW];

  logic [DW-1:0] row0_q, row0_d;
  logic [DW-1:0] row1_q, row1_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          mulIssue;
  logic [DW-1:0] mulA;
  logic [DW-1:0] mulB;
  logic          mulDone;
  logic [DW-1:0] mulRes;

  // Products are issued on even CALC steps: b0*b0, res*b0, b1*b1, res*b1.
  // A result appears two steps after issue, exactly when the dependent
  // product needs it, so it is fed straight back from the multiplier.
  always_comb begin
    mulIssue = (state_q == ST_CALC) && !step_q[0];
    mulB     = step_q[2] ? pw1_q[1] : pw0_q[1];
    mulA     = step_q[1] ? mulRes : mulB;
  end

  goldilocks_mulmod u_mulmod (
    .clk_i   (CLK),
    .rst_i   (rst),
    .valid_i (mulIssue),
    .a_i     (mulA),
    .b_i     (mulB),
    .valid_o (mulDone),
    .res_o   (mulRes)
  );

  // Next-state logic and registered-output precompute. Outputs are derived
  // from the upcoming state so they change on the same edge as the FSM.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    beat_d  = beat_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_CALC;
          step_d  = 3'd0;
        end
      end
      ST_CALC: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = ST_EMIT0;
          beat_d  = '0;
        end
      end
      ST_EMIT0: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = ST_EMIT1;
          beat_d  = '0;
        end
      end
      ST_EMIT1: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = ST_FIN;
          beat_d  = '0;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    code_d = W_IDLE;
    row0_d = '0;
    row1_d = '0;
    if (state_d == ST_EMIT0) begin
      code_d = W_ROW0;
      row0_d = pw0_q[beat_d];
    end else if (state_d == ST_EMIT1) begin
      code_d = W_ROW1;
      row1_d = pw1_q[beat_d];
    end
    busy_d = (state_d == ST_CALC) || (state_d == ST_EMIT0) || (state_d == ST_EMIT1);
    done_d = (state_d == ST_FIN);
  end

  // FSM, counters and output registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      beat_q  <= '0;
      row0_q  <= '0;
      row1_q  <= '0;
      code_q  <= W_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      beat_q  <= beat_d;
      row0_q  <= row0_d;
      row1_q  <= row1_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Power registers. dest_q walks pw0[2], pw0[3], pw1[2], pw1[3] in the
  // order results leave the multiplier; the last one lands during the first
  // row0 beat, well before row1 is emitted.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      dest_q <= '0;
      for (int k = 0; k < N_POW; k++) begin
        pw0_q[k] <= '0;
        pw1_q[k] <= '0;
      end
    end else if (accept) begin
      dest_q   <= '0;
      pw0_q[0] <= ONE;
      pw1_q[0] <= ONE;
      pw0_q[1] <= (base0_in >= P_MOD) ? (base0_in - P_MOD) : base0_in;
      pw1_q[1] <= (base1_in >= P_MOD) ? (base1_in - P_MOD) : base1_in;
    end else if (mulDone) begin
      dest_q <= dest_q + 2'd1;
      case (dest_q)
        2'd0: pw0_q[2] <= mulRes;
        2'd1: pw0_q[3] <= mulRes;
        2'd2: pw1_q[2] <= mulRes;
        2'd3: pw1_q[3] <= mulRes;
        default: ;
      endcase
    end
  end

  assign horizontal_row0_out = row0_q;
  assign horizontal_row1_out = row1_q;
  assign ROM2_w              = code_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_tw_row_gen.sv
// tb_tw_row_gen
// Self-checking bench for tw_row_gen. Expected beats come from a plain
// power-mod model using 128-bit arithmetic and the % operator; the expected
// cycle-by-cycle timeline is written out from the transaction schedule.
module tb_tw_row_gen;

  localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

  logic        CLK;
  logic        rst;
  logic        start;
  logic [63:0] base0_in;
  logic [63:0] base1_in;
  logic [63:0] row0;
  logic [63:0] row1;
  logic [1:0]  ROM2_w;
  logic        busy;
  logic        done;

  int vectorCount = 0;
  int missCount   = 0;

  tw_row_gen dut (
    .CLK                 (CLK),
    .rst                 (rst),
    .start               (start),
    .base0_in            (base0_in),
    .base1_in            (base1_in),
    .horizontal_row0_out (row0),
    .horizontal_row1_out (row1),
    .ROM2_w              (ROM2_w),
    .busy                (busy),
    .done                (done)
  );

  // Free-running 100 MHz clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] modMul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] t;
    t = ({64'd0, a} * {64'd0, b}) % {64'd0, P};
    return t[63:0];
  endfunction

  function automatic logic [63:0] powMod(input logic [63:0] b, input int k);
    logic [63:0] r;
    logic [63:0] bc;
    bc = b % P;
    r  = 64'd1;
    for (int i = 0; i < k; i++) r = modMul(r, bc);
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Checks every output against the schedule for cycle n after E0.
  task automatic checkCycle(input int n, input logic [63:0] b0, input logic [63:0] b1);
    logic [1:0]  expCode;
    logic [63:0] exp0;
    logic [63:0] exp1;
    expCode = 2'd0;
    exp0    = 64'd0;
    exp1    = 64'd0;
    if (n >= 8 && n <= 11) begin
      expCode = 2'd1;
      exp0    = powMod(b0, n - 8);
    end else if (n >= 12 && n <= 15) begin
      expCode = 2'd2;
      exp1    = powMod(b1, n - 12);
    end
    checkOutput($sformatf("code@%0d", n), 64'(ROM2_w), 64'(expCode));
    checkOutput($sformatf("row0@%0d", n), row0, exp0);
    checkOutput($sformatf("row1@%0d", n), row1, exp1);
    checkOutput($sformatf("busy@%0d", n), 64'(busy), 64'(n <= 15));
    checkOutput($sformatf("done@%0d", n), 64'(done), 64'(n == 16));
    if (expCode == 2'd1) checkOutput($sformatf("row0<p@%0d", n), 64'(row0 < P), 64'd1);
    if (expCode == 2'd2) checkOutput($sformatf("row1<p@%0d", n), 64'(row1 < P), 64'd1);
  endtask

  // One full transaction; optionally pulses start at E3/E10 and scrambles
  // the base inputs while busy.
  task automatic applyStimulus(input logic [63:0] b0, input logic [63:0] b1,
                               input bit extraStarts, input bit scramble);
    @(negedge CLK);
    start    = 1'b1;
    base0_in = b0;
    base1_in = b1;
    for (int n = 0; n <= 17; n++) begin
      @(negedge CLK);
      start = extraStarts && (n == 2 || n == 9);
      if (scramble) begin
        base0_in = rand64();
        base1_in = rand64();
      end
      if (n <= 16) begin
        checkCycle(n, b0, b1);
      end else begin
        checkOutput("idleCode", 64'(ROM2_w), 64'd0);
        checkOutput("idleBusy", 64'(busy), 64'd0);
        checkOutput("idleDone", 64'(done), 64'd0);
      end
    end
  endtask

  // Asserts reset during the third row0 beat and checks the asynchronous
  // clear, then lets the generator sit idle.
  task automatic resetMidBurst(input logic [63:0] b0, input logic [63:0] b1);
    @(negedge CLK);
    start    = 1'b1;
    base0_in = b0;
    base1_in = b1;
    for (int n = 0; n <= 10; n++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    checkOutput("preRstCode", 64'(ROM2_w), 64'd1);
    checkOutput("preRstRow0", row0, powMod(b0, 2));
    #1 rst = 1'b1;
    #1;
    checkOutput("rstCode", 64'(ROM2_w), 64'd0);
    checkOutput("rstRow0", row0, 64'd0);
    checkOutput("rstRow1", row1, 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    @(negedge CLK);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge CLK);
      checkOutput("postRstCode", 64'(ROM2_w), 64'd0);
      checkOutput("postRstBusy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] r0;
    logic [63:0] r1;
    rst      = 1'b1;
    start    = 1'b0;
    base0_in = 64'd0;
    base1_in = 64'd0;
    repeat (2) @(negedge CLK);
    checkOutput("resetCode", 64'(ROM2_w), 64'd0);
    checkOutput("resetRow0", row0, 64'd0);
    checkOutput("resetRow1", row1, 64'd0);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetDone", 64'(done), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("releaseBusy", 64'(busy), 64'd0);

    applyStimulus(64'h0000_0001_0000_0000, 64'd2, 1'b0, 1'b0);
    applyStimulus(P - 64'd1, 64'd1, 1'b0, 1'b0);
    applyStimulus(P, P + 64'd5, 1'b0, 1'b0);
    applyStimulus(rand64() % P, rand64() % P, 1'b1, 1'b1);
    resetMidBurst(64'd3, 64'd7);
    applyStimulus(64'd3, 64'd7, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      r0 = rand64() % P;
      r1 = rand64() % P;
      applyStimulus(r0, r1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
